// File: rtl/handshake_seq_checker.sv
// handshake_seq_checker
//   Downstream sink for a valid/ready stream. It applies constant or LFSR-driven
//   backpressure and checks that the received data forms an incrementing sequence.
//   It counts beats, data errors and stall cycles, and flags upstream protocol
//   violations (valid dropped or data changed while stalled).
// Ports
//   clk, reset_n        clock (rising edge), async active-low reset
//   start_i             begin a run (honoured in IDLE/DONE only)
//   ready_en_i          external ready gate
//   valid_i, data_i     upstream beat
//   ready_o             ready to upstream (from registered state/lfsr and ready_en_i)
//   done_o, pass_o      run complete / run complete with no data or protocol error
//   err_cnt_o           data mismatches (saturating)
//   beat_cnt_o          transfers accepted this run
//   stall_cnt_o         valid & ~ready cycles in RUN (saturating)
//   proto_err_o         sticky upstream protocol violation
module handshake_seq_checker #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned NUM_BEATS    = 200,
  parameter int unsigned FIRST_VALUE  = 1,
  parameter int unsigned RANDOM_READY = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              ready_en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_cnt_o,
  output logic [15:0]       beat_cnt_o,
  output logic [15:0]       stall_cnt_o,
  output logic              proto_err_o
);

  localparam int unsigned    CNT_W      = 16;
  localparam int unsigned    LFSR_W     = 16;
  // A zero seed would lock the LFSR, so it is replaced by the default.
  localparam logic [LFSR_W-1:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  // Galois right-shift toggle mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DATA_W-1:0] FIRST_DATA = DATA_W'(FIRST_VALUE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   expect_q, expect_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                proto_err_q, proto_err_d;
  logic                prev_stall_q, prev_stall_d;
  logic [DATA_W-1:0]   prev_data_q, prev_data_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                in_run_c;
  logic                ready_c;
  logic                xfer_c;
  logic                stall_c;
  logic                start_run_c;

  // Ready is a function of registered state only plus the external gate.
  assign in_run_c = (state_q == S_RUN);
  assign ready_c  = in_run_c & ready_en_i & ((RANDOM_READY != 0) ? lfsr_q[0] : 1'b1);
  assign xfer_c   = in_run_c & valid_i & ready_c;
  assign stall_c  = in_run_c & valid_i & ~ready_c;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    expect_d     = expect_q;
    beat_cnt_d   = beat_cnt_q;
    err_cnt_d    = err_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    proto_err_d  = proto_err_q;
    prev_stall_d = prev_stall_q;
    prev_data_d  = prev_data_q;
    start_run_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) start_run_c = 1'b1;
      end
      S_RUN: begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        if (xfer_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // Expected value free-runs so one bad beat costs exactly one error.
          expect_d   = expect_q + DATA_W'(1);
          if ((data_i != expect_q) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (beat_cnt_q == LAST_BEAT) state_d = S_DONE;
        end
        if (stall_c && (stall_cnt_q != CNT_MAX)) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        // A stalled beat must stay valid with unchanged data.
        if (prev_stall_q && (!valid_i || (data_i != prev_data_q))) begin
          proto_err_d = 1'b1;
        end
        prev_stall_d = stall_c;
        prev_data_d  = data_i;
      end
      S_DONE: begin
        if (start_i) start_run_c = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Fresh run: clear results and restart the sequence and LFSR.
    if (start_run_c) begin
      state_d      = S_RUN;
      lfsr_d       = SEED_EFF;
      expect_d     = FIRST_DATA;
      beat_cnt_d   = '0;
      err_cnt_d    = '0;
      stall_cnt_d  = '0;
      proto_err_d  = 1'b0;
      prev_stall_d = 1'b0;
    end

    done_d = (state_d == S_DONE);
    pass_d = done_d & (err_cnt_d == '0) & ~proto_err_d;
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      expect_q     <= FIRST_DATA;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      proto_err_q  <= 1'b0;
      prev_stall_q <= 1'b0;
      prev_data_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      expect_q     <= expect_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      proto_err_q  <= proto_err_d;
      prev_stall_q <= prev_stall_d;
      prev_data_q  <= prev_data_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign ready_o     = ready_c;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_cnt_q;
  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_handshake_seq_checker.sv
// Bench for handshake_seq_checker: two instances, one with constant ready
// (200 beats from 1) and one with LFSR ready (300 beats from 250, wrapping).
module tb_handshake_seq_checker;

  logic        clk;
  logic        reset_n;

  logic        a_start, a_ren, a_valid;
  logic [7:0]  a_data;
  logic        a_ready, a_done, a_pass, a_proto;
  logic [15:0] a_err, a_beat, a_stall;

  logic        b_start, b_ren, b_valid;
  logic [7:0]  b_data;
  logic        b_ready, b_done, b_pass, b_proto;
  logic [15:0] b_err, b_beat, b_stall;

  int n_vec;
  int n_err;

  handshake_seq_checker #(
    .DATA_W(8), .NUM_BEATS(200), .FIRST_VALUE(1), .RANDOM_READY(0), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start_i(a_start), .ready_en_i(a_ren),
    .valid_i(a_valid), .data_i(a_data), .ready_o(a_ready), .done_o(a_done),
    .pass_o(a_pass), .err_cnt_o(a_err), .beat_cnt_o(a_beat),
    .stall_cnt_o(a_stall), .proto_err_o(a_proto)
  );

  handshake_seq_checker #(
    .DATA_W(8), .NUM_BEATS(300), .FIRST_VALUE(250), .RANDOM_READY(1), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start_i(b_start), .ready_en_i(b_ren),
    .valid_i(b_valid), .data_i(b_data), .ready_o(b_ready), .done_o(b_done),
    .pass_o(b_pass), .err_cnt_o(b_err), .beat_cnt_o(b_beat),
    .stall_cnt_o(b_stall), .proto_err_o(b_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Per-cycle table record: inputs, ready before the edge, results after it.
  typedef struct {
    logic        start;
    logic        ren;
    logic        valid;
    logic [7:0]  data;
    logic        ex_ready;
    logic [15:0] ex_beat;
    logic [15:0] ex_err;
    logic [15:0] ex_stall;
    logic        ex_proto;
  } vec_t;

  vec_t tbl[12];

  // One full or partial run on dut_a with ready always granted.
  task automatic run_a(input int bad_idx, input logic [7:0] bad_val, input int n);
    a_start = 1'b1; a_valid = 1'b0; a_ren = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_data  = (i == bad_idx) ? bad_val : 8'(i + 1);
      #1 chk("a_run_ready", a_ready, 1);
      @(negedge clk);
      chk("a_run_done", a_done, (i == 199) ? 1 : 0);
    end
    a_valid = 1'b0;
  endtask

  // Randomized run on dut_b against a model built from the sequence rules.
  task automatic run_b(input bit inject);
    int          sent;
    int          m_err;
    int          m_stall;
    int          cyc;
    logic [15:0] m_lfsr;
    bit          hold;
    logic [7:0]  hd;
    logic        exp_rdy;
    sent = 0; m_err = 0; m_stall = 0; cyc = 0; hold = 0; hd = 8'd0;
    b_start = 1'b1; b_valid = 1'b0; b_ren = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    m_lfsr  = 16'hACE1;
    while (sent < 300 && cyc < 4000) begin
      if (!hold) begin
        hold = ($urandom_range(0, 1) == 1);
        if (hold) begin
          hd = 8'(250 + sent);
          if (inject && $urandom_range(0, 15) == 0) begin
            hd = hd ^ 8'h5A;
            m_err++;
          end
        end
      end
      b_valid = hold;
      b_data  = hold ? hd : 8'($urandom);
      b_ren   = ($urandom_range(0, 7) != 0);
      exp_rdy = b_ren & m_lfsr[0];
      #1 chk("b_ready", b_ready, exp_rdy);
      if (hold && exp_rdy) begin
        sent++;
        hold = 0;
      end else if (hold) begin
        m_stall++;
      end
      // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1.
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      cyc++;
      @(negedge clk);
      chk("b_beat", b_beat, sent);
      chk("b_done", b_done, (sent == 300) ? 1 : 0);
    end
    if (sent < 300) begin
      n_vec++;
      n_err++;
      $display("FAIL b_timeout: got %0d beats expected 300", sent);
    end
    b_valid = 1'b0;
    chk("b_err",   b_err,   m_err);
    chk("b_stall", b_stall, m_stall);
    chk("b_proto", b_proto, 0);
    chk("b_pass",  b_pass,  (m_err == 0) ? 1 : 0);
    b_ren = 1'b1; b_valid = 1'b1;
    #1 chk("b_done_ready", b_ready, 0);
    @(negedge clk);
    chk("b_frozen_beat",  b_beat,  300);
    chk("b_frozen_stall", b_stall, m_stall);
    b_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clk = 1'b0; reset_n = 1'b0;
    a_start = 1'b0; a_ren = 1'b0; a_valid = 1'b0; a_data = 8'd0;
    b_start = 1'b0; b_ren = 1'b0; b_valid = 1'b0; b_data = 8'd0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 16'd1, 16'd0, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 16'd1, 16'd0, 16'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 16'd1, 16'd0, 16'd2, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 16'd2, 16'd0, 16'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'd9, 1'b1, 16'd3, 16'd1, 16'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 16'd3, 16'd1, 16'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 16'd4, 16'd1, 16'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 16'd5, 16'd1, 16'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 16'd5, 16'd1, 16'd3, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd6, 1'b0, 16'd5, 16'd1, 16'd3, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 16'd6, 16'd1, 16'd3, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_done",  a_done,  0);
    chk("rst_a_pass",  a_pass,  0);
    chk("rst_a_beat",  a_beat,  0);
    chk("rst_a_err",   a_err,   0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_a_proto", a_proto, 0);
    chk("rst_b_done",  b_done,  0);
    chk("rst_b_beat",  b_beat,  0);
    reset_n = 1'b1;
    @(negedge clk);
    a_ren = 1'b1;
    #1 chk("idle_a_ready", a_ready, 0);
    @(negedge clk);

    // Table: start, stalls, bad beat, ignored start, dropped valid
    for (int i = 0; i < 12; i++) begin
      a_start = tbl[i].start; a_ren = tbl[i].ren;
      a_valid = tbl[i].valid; a_data = tbl[i].data;
      #1 chk($sformatf("tbl%0d_ready", i), a_ready, tbl[i].ex_ready);
      @(negedge clk);
      chk($sformatf("tbl%0d_beat", i),  a_beat,  tbl[i].ex_beat);
      chk($sformatf("tbl%0d_err", i),   a_err,   tbl[i].ex_err);
      chk($sformatf("tbl%0d_stall", i), a_stall, tbl[i].ex_stall);
      chk($sformatf("tbl%0d_proto", i), a_proto, tbl[i].ex_proto);
      chk($sformatf("tbl%0d_done", i),  a_done,  0);
    end
    a_start = 1'b0; a_valid = 1'b0; a_ren = 1'b1;

    // Asynchronous reset in RUN drops ready without a clock edge
    #1 chk("pre_rst_ready", a_ready, 1);
    #1 reset_n = 1'b0;
    #1 chk("async_rst_ready", a_ready, 0);
    chk("async_rst_beat",  a_beat,  0);
    chk("async_rst_proto", a_proto, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean 200-beat run
    run_a(-1, 8'd0, 200);
    chk("clean_beat",  a_beat,  200);
    chk("clean_err",   a_err,   0);
    chk("clean_stall", a_stall, 0);
    chk("clean_proto", a_proto, 0);
    chk("clean_pass",  a_pass,  1);
    #1 chk("done_ready", a_ready, 0);
    a_valid = 1'b1;
    @(negedge clk);
    chk("frozen_beat",  a_beat,  200);
    chk("frozen_stall", a_stall, 0);
    chk("frozen_done",  a_done,  1);
    a_valid = 1'b0;

    // Beat 50 corrupted: exactly one error
    run_a(49, 8'd99, 200);
    chk("bad50_err",  a_err,  1);
    chk("bad50_beat", a_beat, 200);
    chk("bad50_pass", a_pass, 0);

    // Data changed 5 -> 6 while stalled
    a_start = 1'b1; a_valid = 1'b0; a_ren = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      a_valid = 1'b1; a_data = 8'(v);
      @(negedge clk);
    end
    a_ren = 1'b0; a_data = 8'd5;
    @(negedge clk);
    chk("chg_stall1", a_stall, 1);
    chk("chg_proto1", a_proto, 0);
    a_data = 8'd6;
    @(negedge clk);
    chk("chg_stall2", a_stall, 2);
    chk("chg_proto2", a_proto, 1);
    a_ren = 1'b1;
    for (int v = 5; v <= 200; v++) begin
      a_data = 8'(v);
      @(negedge clk);
    end
    a_valid = 1'b0;
    chk("chg_done",  a_done,  1);
    chk("chg_beat",  a_beat,  200);
    chk("chg_err",   a_err,   0);
    chk("chg_proto", a_proto, 1);
    chk("chg_pass",  a_pass,  0);

    // Reset at beat 100, then a fresh run
    run_a(-1, 8'd0, 100);
    chk("mid_beat", a_beat, 100);
    chk("mid_done", a_done, 0);
    #1 chk("mid_ready", a_ready, 1);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_beat", a_beat, 0);
    chk("mid_rst_done", a_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_a(-1, 8'd0, 200);
    chk("fresh_beat", a_beat, 200);
    chk("fresh_pass", a_pass, 1);

    // LFSR backpressure, wrap 255 -> 0, clean then with injected errors
    run_b(1'b0);
    run_b(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
